// File: rtl/vga_timing_gen.sv
// vga_timing_gen -- parametrised VGA raster timing generator.
//
// Owns the horizontal/vertical raster counters and decodes the line/frame
// markers, sync pulses and video-active window from the porch/sync parameters.
// Every flag is registered, and each one is decoded from the next-state counter
// values, so it lines up with hCount/vCount on the same cycle.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   pix_en       pixel tick; nothing changes on clocks where this is 0
//   hCount       horizontal position (CNT_W bits)
//   vCount       vertical position (CNT_W bits)
//   hsync/vsync  sync outputs, SYNC_ACT while inside the sync window
//   video_on     hCount < H_VISIBLE and vCount < V_VISIBLE
//   fim_h        last pixel of a line   (hCount == H_TOTAL-1)
//   fim_v        last pixel of a frame  (also vCount == V_TOTAL-1)
//   frame_start  one-tick pulse at (0,0)
//   frame_cnt    completed-frame count (FRAME_W bits)
//
// Optional build macro VGA_FRAME_CNT_EN: when defined, frame_cnt counts
// completed frames modulo 2**FRAME_W. When it is undefined, frame_cnt is
// tied to 0.
module vga_timing_gen #(
  parameter int CNT_W     = 10,
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit SYNC_ACT  = 1'b0,
  parameter int FRAME_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pix_en,
  output logic [CNT_W-1:0]   hCount,
  output logic [CNT_W-1:0]   vCount,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on,
  output logic               fim_h,
  output logic               fim_v,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  if (H_TOTAL > 2**CNT_W || V_TOTAL > 2**CNT_W) begin : g_bad_cnt_w
    $error("vga_timing_gen: H_TOTAL/V_TOTAL do not fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS  = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] V_VIS  = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_VISIBLE + H_FRONT);
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_VISIBLE + V_FRONT);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic [CNT_W-1:0] h_nxt, v_nxt;
  logic             h_wrap, v_wrap;

  always_comb begin
    h_wrap = (hCount == H_LAST);
    v_wrap = (vCount == V_LAST);
    h_nxt  = h_wrap ? '0 : hCount + CNT_W'(1);
    v_nxt  = vCount;
    if (h_wrap) v_nxt = v_wrap ? '0 : vCount + CNT_W'(1);
  end

  // Reset parks the raster on the last pixel of the frame, so the first tick
  // after release wraps to (0,0). The flags reset to 0 here even though that
  // position would decode as fim_h/fim_v.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hCount      <= H_LAST;
      vCount      <= V_LAST;
      hsync       <= ~SYNC_ACT;
      vsync       <= ~SYNC_ACT;
      video_on    <= 1'b0;
      fim_h       <= 1'b0;
      fim_v       <= 1'b0;
      frame_start <= 1'b0;
    end else if (pix_en) begin
      hCount      <= h_nxt;
      vCount      <= v_nxt;
      hsync       <= (h_nxt >= HS_BEG && h_nxt <= HS_END) ? SYNC_ACT : ~SYNC_ACT;
      vsync       <= (v_nxt >= VS_BEG && v_nxt <= VS_END) ? SYNC_ACT : ~SYNC_ACT;
      video_on    <= (h_nxt < H_VIS) && (v_nxt < V_VIS);
      fim_h       <= (h_nxt == H_LAST);
      fim_v       <= (h_nxt == H_LAST) && (v_nxt == V_LAST);
      frame_start <= (h_nxt == '0) && (v_nxt == '0);
    end
  end

`ifdef VGA_FRAME_CNT_EN
  // fim_v is held low by reset, so the wrap that follows reset release is
  // not counted. Only genuine end-of-frame wraps increment the count.
  logic [FRAME_W-1:0] frame_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               frame_q <= '0;
    else if (pix_en && fim_v) frame_q <= frame_q + FRAME_W'(1);
  end

  assign frame_cnt = frame_q;
`else
  assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen. It uses two instances:
//   u_a : default 640x480 timing, active-low syncs
//   u_b : small raster (H 16/2/4/2 = 24, V 12/2/2/2 = 18), active-high syncs,
//         FRAME_W=2, so that whole frames fit in a short run
// Expected values come from hand-written decode windows applied to bench-side
// position counters.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pix_en = 1'b0;
  always #5 clk = ~clk;

  logic [9:0] a_hc, a_vc;
  logic       a_hs, a_vs, a_vo, a_fh, a_fv, a_fs;
  logic [7:0] a_fc;
  logic [5:0] b_hc, b_vc;
  logic       b_hs, b_vs, b_vo, b_fh, b_fv, b_fs;
  logic [1:0] b_fc;

  vga_timing_gen u_a (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
    .hCount(a_hc), .vCount(a_vc), .hsync(a_hs), .vsync(a_vs),
    .video_on(a_vo), .fim_h(a_fh), .fim_v(a_fv), .frame_start(a_fs),
    .frame_cnt(a_fc)
  );

  vga_timing_gen #(
    .CNT_W(6), .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(2),
    .V_VISIBLE(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(2),
    .SYNC_ACT(1'b1), .FRAME_W(2)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
    .hCount(b_hc), .vCount(b_vc), .hsync(b_hs), .vsync(b_vs),
    .video_on(b_vo), .fim_h(b_fh), .fim_v(b_fv), .frame_start(b_fs),
    .frame_cnt(b_fc)
  );

  logic [33:0] obs_a;
  logic [19:0] obs_b;
  assign obs_a = {a_hc, a_vc, a_hs, a_vs, a_vo, a_fh, a_fv, a_fs, a_fc};
  assign obs_b = {b_hc, b_vc, b_hs, b_vs, b_vo, b_fh, b_fv, b_fs, b_fc};

  int checks = 0;
  int errors = 0;

  // Bench-side raster positions. fresh marks the parked post-reset state.
  int mh_a, mv_a, mh_b, mv_b, m_fc;
  bit fresh;

  function automatic logic [33:0] exp_a(int h, int v, bit f);
    logic [5:0] fl;
    if (f) fl = 6'b110000;
    else   fl = {!(h >= 656 && h <= 751), !(v >= 490 && v <= 491),
                 (h < 640 && v < 480), (h == 799), (h == 799 && v == 524),
                 (h == 0 && v == 0)};
    return {10'(h), 10'(v), fl, 8'd0};
  endfunction

  function automatic logic [19:0] exp_b(int h, int v, bit f, int fc);
    logic [5:0] fl;
    logic [1:0] fcv;
    if (f) fl = 6'b000000;
    else   fl = {(h >= 18 && h <= 21), (v >= 14 && v <= 15),
                 (h < 16 && v < 12), (h == 23), (h == 23 && v == 17),
                 (h == 0 && v == 0)};
`ifdef VGA_FRAME_CNT_EN
    fcv = 2'(fc);
`else
    fcv = 2'(fc * 0);
`endif
    return {6'(h), 6'(v), fl, fcv};
  endfunction

  task automatic model_reset();
    mh_a = 799; mv_a = 524; mh_b = 23; mv_b = 17; m_fc = 0; fresh = 1'b1;
  endtask

  // One clock with the given pix_en, then step the bench positions.
  task automatic tick(input logic e);
    pix_en = e;
    @(posedge clk);
    #1;
    if (e) begin
      if (mh_a == 799) begin mh_a = 0; mv_a = (mv_a == 524) ? 0 : mv_a + 1; end
      else mh_a++;
      if (mh_b == 23) begin
        if (mv_b == 17 && !fresh) m_fc++;
        mh_b = 0; mv_b = (mv_b == 17) ? 0 : mv_b + 1;
      end else mh_b++;
      fresh = 1'b0;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; pix_en = 1'b0;
    model_reset();
    #2;
    checks++;
    if (obs_a !== exp_a(mh_a, mv_a, fresh)) begin
      errors++; $display("FAIL reset_a got=%h exp=%h", obs_a, exp_a(mh_a, mv_a, fresh));
    end
    checks++;
    if (obs_b !== exp_b(mh_b, mv_b, fresh, m_fc)) begin
      errors++; $display("FAIL reset_b got=%h exp=%h", obs_b, exp_b(mh_b, mv_b, fresh, m_fc));
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    // With pix_en low after release, everything stays parked.
    for (int i = 0; i < 3; i++) begin
      tick(1'b0);
      checks++;
      if (obs_a !== exp_a(mh_a, mv_a, fresh)) begin
        errors++; $display("FAIL idle_a i=%0d got=%h exp=%h", i, obs_a, exp_a(mh_a, mv_a, fresh));
      end
      checks++;
      if (obs_b !== exp_b(mh_b, mv_b, fresh, m_fc)) begin
        errors++; $display("FAIL idle_b i=%0d got=%h exp=%h", i, obs_b, exp_b(mh_b, mv_b, fresh, m_fc));
      end
    end
  endtask

  task automatic test_first_tick();
    tick(1'b1);
    checks++;
    if (obs_a !== {10'd0, 10'd0, 6'b111001, 8'd0}) begin
      errors++; $display("FAIL first_a got=%h exp=%h", obs_a, {10'd0, 10'd0, 6'b111001, 8'd0});
    end
    checks++;
    if (obs_b !== {6'd0, 6'd0, 6'b001001, 2'd0}) begin
      errors++; $display("FAIL first_b got=%h exp=%h", obs_b, {6'd0, 6'd0, 6'b001001, 2'd0});
    end
  endtask

  // 2400 ticks: three full lines of u_a and five-plus frames of u_b.
  task automatic test_line_scan();
    int hs_cnt, vo_cnt, fh_cnt, bvs_cnt, bfv_cnt, bfs_cnt;
    logic [1:0] fc_seq[$];
    logic [1:0] fc_exp[5];
    hs_cnt = 0; vo_cnt = 0; fh_cnt = 0; bvs_cnt = 0; bfv_cnt = 0; bfs_cnt = 0;
    for (int i = 0; i < 2400; i++) begin
      tick(1'b1);
      checks++;
      if (obs_a !== exp_a(mh_a, mv_a, fresh)) begin
        errors++; $display("FAIL scan_a h=%0d v=%0d got=%h exp=%h", mh_a, mv_a, obs_a, exp_a(mh_a, mv_a, fresh));
      end
      checks++;
      if (obs_b !== exp_b(mh_b, mv_b, fresh, m_fc)) begin
        errors++; $display("FAIL scan_b h=%0d v=%0d got=%h exp=%h", mh_b, mv_b, obs_b, exp_b(mh_b, mv_b, fresh, m_fc));
      end
      if (a_hs === 1'b0) hs_cnt++;
      if (a_vo === 1'b1) vo_cnt++;
      if (a_fh === 1'b1) fh_cnt++;
      if (b_vs === 1'b1) bvs_cnt++;
      if (b_fv === 1'b1) bfv_cnt++;
      if (b_fs === 1'b1) begin bfs_cnt++; fc_seq.push_back(b_fc); end
    end
    checks++;
    if (hs_cnt != 288) begin errors++; $display("FAIL hsync_ticks got=%0d exp=288", hs_cnt); end
    checks++;
    if (vo_cnt != 1920) begin errors++; $display("FAIL video_on_ticks got=%0d exp=1920", vo_cnt); end
    checks++;
    if (fh_cnt != 3) begin errors++; $display("FAIL fim_h_count got=%0d exp=3", fh_cnt); end
    checks++;
    if (bvs_cnt != 240) begin errors++; $display("FAIL b_vsync_ticks got=%0d exp=240", bvs_cnt); end
    checks++;
    if (bfv_cnt != 5) begin errors++; $display("FAIL b_fim_v_count got=%0d exp=5", bfv_cnt); end
    checks++;
    if (bfs_cnt != 5) begin errors++; $display("FAIL b_frame_start_count got=%0d exp=5", bfs_cnt); end
`ifdef VGA_FRAME_CNT_EN
    fc_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
`else
    fc_exp = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`endif
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (k >= fc_seq.size()) begin
        errors++; $display("FAIL frame_cnt_seq k=%0d got=none exp=%0d", k, fc_exp[k]);
      end else if (fc_seq[k] !== fc_exp[k]) begin
        errors++; $display("FAIL frame_cnt_seq k=%0d got=%0d exp=%0d", k, fc_seq[k], fc_exp[k]);
      end
    end
  endtask

  // Alternate pix_en 0/1. Outputs must hold on the 0 clocks, and a u_b frame
  // must take 2*432 = 864 clocks.
  task automatic test_pix_en_toggle();
    int clk_idx, first_rise, second_rise;
    bit prev_fs;
    clk_idx = 0; first_rise = -1; second_rise = -1;
    prev_fs = (mh_b == 0 && mv_b == 0);
    for (int i = 0; i < 1728; i++) begin
      tick(i[0]);
      clk_idx++;
      checks++;
      if (obs_a !== exp_a(mh_a, mv_a, fresh)) begin
        errors++; $display("FAIL toggle_a i=%0d got=%h exp=%h", i, obs_a, exp_a(mh_a, mv_a, fresh));
      end
      checks++;
      if (obs_b !== exp_b(mh_b, mv_b, fresh, m_fc)) begin
        errors++; $display("FAIL toggle_b i=%0d got=%h exp=%h", i, obs_b, exp_b(mh_b, mv_b, fresh, m_fc));
      end
      if (b_fs === 1'b1 && !prev_fs) begin
        if (first_rise < 0) first_rise = clk_idx;
        else if (second_rise < 0) second_rise = clk_idx;
      end
      prev_fs = (b_fs === 1'b1);
    end
    checks++;
    if (first_rise < 0 || second_rise < 0 || second_rise - first_rise != 864) begin
      errors++; $display("FAIL toggle_period got=%0d exp=864", second_rise - first_rise);
    end
  endtask

  task automatic test_mid_reset();
    int n;
    n = 0;
    while (mh_a != 300 && n < 1000) begin tick(1'b1); n++; end
    checks++;
    if (mh_a != 300) begin errors++; $display("FAIL seek_300 got=%0d exp=300", mh_a); end
    checks++;
    if (obs_a !== exp_a(mh_a, mv_a, fresh)) begin
      errors++; $display("FAIL pre_reset_a got=%h exp=%h", obs_a, exp_a(mh_a, mv_a, fresh));
    end
    // Assert reset between clock edges. The outputs must react with no edge.
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (obs_a !== exp_a(mh_a, mv_a, fresh)) begin
      errors++; $display("FAIL async_reset_a got=%h exp=%h", obs_a, exp_a(mh_a, mv_a, fresh));
    end
    checks++;
    if (obs_b !== exp_b(mh_b, mv_b, fresh, m_fc)) begin
      errors++; $display("FAIL async_reset_b got=%h exp=%h", obs_b, exp_b(mh_b, mv_b, fresh, m_fc));
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    // Resume from (0,0), then run one full u_b frame so that one real wrap
    // is counted and the reset-release wrap is not.
    for (int i = 0; i < 433; i++) begin
      tick(1'b1);
      checks++;
      if (obs_a !== exp_a(mh_a, mv_a, fresh)) begin
        errors++; $display("FAIL resume_a i=%0d got=%h exp=%h", i, obs_a, exp_a(mh_a, mv_a, fresh));
      end
      checks++;
      if (obs_b !== exp_b(mh_b, mv_b, fresh, m_fc)) begin
        errors++; $display("FAIL resume_b i=%0d got=%h exp=%h", i, obs_b, exp_b(mh_b, mv_b, fresh, m_fc));
      end
    end
    checks++;
`ifdef VGA_FRAME_CNT_EN
    if (b_fc !== 2'd1) begin errors++; $display("FAIL resume_frame_cnt got=%0d exp=1", b_fc); end
`else
    if (b_fc !== 2'd0) begin errors++; $display("FAIL resume_frame_cnt got=%0d exp=0", b_fc); end
`endif
  endtask

  initial begin
    model_reset();
    test_reset();
    test_first_tick();
    test_line_scan();
    test_pix_en_toggle();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
